// File: rtl/aes_seq_engine.sv
// aes_seq_engine: iterative AES encryptor, one round per clock.
// NK selects AES-128/192/256 (4/6/8 key words); NR = NK+6 rounds.
// Optional build macro AES_SEQ_STATS_EN adds a 32-bit completed-block counter.
module aes_seq_engine #(
  parameter int NK = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [127:0]    in,
  input  logic [32*NK-1:0] key,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [127:0]    out,
  output logic            busy
`ifdef AES_SEQ_STATS_EN
  ,
  output logic [31:0]     blk_count
`endif
);

  localparam int NR = NK + 6;
  localparam int NW = 4 * (NR + 1);

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

  state_t                 fsm;
  logic [3:0]             rnd;
  logic [32*NK-1:0]       key_q;
  logic [127:0]           st;
  logic [128*(NR+1)-1:0]  sched;
  logic [127:0]           rk;
  logic [127:0]           rk0;
  logic [127:0]           rnd_out;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // S-box as GF(2^8) inverse (a^254) followed by the affine transform
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] a3, a7, a15, a31, a63, a127, v;
    a3   = gmul(gmul(a, a), a);
    a7   = gmul(gmul(a3, a3), a);
    a15  = gmul(gmul(a7, a7), a);
    a31  = gmul(gmul(a15, a15), a);
    a63  = gmul(gmul(a31, a31), a);
    a127 = gmul(gmul(a63, a63), a);
    v    = gmul(a127, a127);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^
           {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // Full FIPS-197 key schedule; round key r sits at bits [128*(NR-r) +: 128]
  function automatic logic [128*(NR+1)-1:0] expand(input logic [32*NK-1:0] k);
    logic [31:0]           w [NW];
    logic [31:0]           t;
    logic [7:0]            rc;
    logic [128*(NR+1)-1:0] r;
    rc = 8'h01;
    for (int i = 0; i < NK; i++) w[i] = k[32*(NK-1-i) +: 32];
    for (int i = NK; i < NW; i++) begin
      t = w[i-1];
      if (i % NK == 0) begin
        t  = subword({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
        rc = xtime(rc);
      end else if (NK > 6 && i % NK == 4) begin
        t = subword(t);
      end
      w[i] = w[i-NK] ^ t;
    end
    for (int i = 0; i < NW; i++) r[32*(NW-1-i) +: 32] = w[i];
    return r;
  endfunction

  // SubBytes, ShiftRows, MixColumns (skipped on the last round), AddRoundKey
  function automatic logic [127:0] aes_round(input logic [127:0] s,
                                             input logic [127:0] k,
                                             input logic         last);
    logic [7:0]   a [16];
    logic [7:0]   b [16];
    logic [7:0]   m [16];
    logic [127:0] r;
    for (int i = 0; i < 16; i++) a[i] = sbox(s[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int j = 0; j < 4; j++)
        b[4*c+j] = a[4*((c+j)%4)+j];
    for (int c = 0; c < 4; c++) begin
      m[4*c+0] = xtime(b[4*c]) ^ xtime(b[4*c+1]) ^ b[4*c+1] ^ b[4*c+2] ^ b[4*c+3];
      m[4*c+1] = b[4*c] ^ xtime(b[4*c+1]) ^ xtime(b[4*c+2]) ^ b[4*c+2] ^ b[4*c+3];
      m[4*c+2] = b[4*c] ^ b[4*c+1] ^ xtime(b[4*c+2]) ^ xtime(b[4*c+3]) ^ b[4*c+3];
      m[4*c+3] = xtime(b[4*c]) ^ b[4*c] ^ b[4*c+1] ^ b[4*c+2] ^ xtime(b[4*c+3]);
    end
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = last ? b[i] : m[i];
    return r ^ k;
  endfunction

  assign sched   = expand(key_q);
  assign rk0     = key[32*NK-1 -: 128];
  assign rnd_out = aes_round(st, rk, rnd == 4'(NR));

  // Round-key select from the registered key's schedule by round counter
  always_comb begin
    rk = sched[0 +: 128];
    for (int r = 0; r <= NR; r++)
      if (rnd == 4'(r)) rk = sched[128*(NR-r) +: 128];
  end

  // Control FSM with registered handshakes; state/key words are data-only
  always_ff @(posedge clk) begin
    if (reset) begin
      fsm       <= IDLE;
      out       <= 128'd0;
      out_valid <= 1'b0;
      rnd       <= 4'd0;
      busy      <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (fsm)
        IDLE: begin
          if (in_valid && in_ready) begin
            key_q    <= key;
            st       <= in ^ rk0;
            rnd      <= 4'd1;
            fsm      <= ROUND;
            busy     <= 1'b1;
            in_ready <= 1'b0;
          end
        end
        ROUND: begin
          st <= rnd_out;
          if (rnd == 4'(NR)) begin
            out       <= rnd_out;
            out_valid <= 1'b1;
            fsm       <= DONE;
          end else begin
            rnd <= rnd + 4'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            fsm       <= IDLE;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

`ifdef AES_SEQ_STATS_EN
  // Count blocks delivered to the consumer; wraps naturally
  always_ff @(posedge clk) begin
    if (reset) blk_count <= 32'd0;
    else if (out_valid && out_ready) blk_count <= blk_count + 32'd1;
  end
`endif

endmodule
